// File: rtl/cordic_xy_rotator.sv
// Iterative CORDIC x/y rotator: applies one upstream direction beat per iteration
// to a gain-compensated unit vector and registers cos/sin with a one-cycle done pulse.
module cordic_xy_rotator #(
  parameter int WIDTH  = 18,
  parameter int ITER   = 16,
  parameter int X_INIT = 39797
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    dir_valid,
  input  logic                    dir_neg,
  output logic                    dir_ready,
  output logic [4:0]              iter_idx,
  output logic                    busy,
  output logic                    done,
  output logic signed [WIDTH-1:0] cos_out,
  output logic signed [WIDTH-1:0] sin_out
);

  typedef enum logic [1:0] {S_IDLE, S_ROTATE, S_DONE} state_t;

  localparam logic signed [WIDTH-1:0] X0       = WIDTH'(X_INIT);
  localparam logic [4:0]              LAST_IDX = 5'(ITER - 1);

  state_t                  r_state;
  logic signed [WIDTH-1:0] r_x, r_y, r_cos, r_sin;
  logic [4:0]              r_idx;
  logic                    r_done;

  // Both shifted terms come from the pre-update vector of the same cycle.
  logic signed [WIDTH-1:0] w_xs, w_ys;
  assign w_xs = r_x >>> r_idx;
  assign w_ys = r_y >>> r_idx;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_cos   <= '0;
      r_sin   <= '0;
      r_idx   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_x     <= X0;
            r_y     <= '0;
            r_idx   <= '0;
            r_state <= S_ROTATE;
          end
        end
        S_ROTATE: begin
          if (dir_valid) begin
            if (dir_neg) begin
              r_x <= r_x + w_ys;
              r_y <= r_y - w_xs;
            end else begin
              r_x <= r_x - w_ys;
              r_y <= r_y + w_xs;
            end
            r_idx <= r_idx + 5'd1;
            if (r_idx == LAST_IDX) r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_cos   <= r_x;
          r_sin   <= r_y;
          r_done  <= 1'b1;
          r_idx   <= '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign dir_ready = (r_state == S_ROTATE);
  assign busy      = (r_state != S_IDLE);
  assign iter_idx  = r_idx;
  assign done      = r_done;
  assign cos_out   = r_cos;
  assign sin_out   = r_sin;

endmodule

// File: tb/tb_cordic_xy_rotator.sv
// Scoreboard bench for cordic_xy_rotator: directed all-positive/all-negative runs,
// stalls, ignored start/dir_valid, and an asynchronous mid-run reset.
module tb_cordic_xy_rotator;
  localparam int WIDTH = 18;
  localparam int ITER  = 16;
  localparam int TOL   = 16;
  // Hand-computed: sum of atan(2^-i), i=0..15 = 1.74329 rad.
  localparam int COS_E = -11253;
  localparam int SIN_E = 64563;

  logic clock = 1'b0;
  logic reset_n, start, dir_valid, dir_neg;
  logic dir_ready, busy, done;
  logic [4:0] iter_idx;
  logic signed [WIDTH-1:0] cos_out, sin_out;

  typedef struct {int c; int s; int tol; int cyc;} exp_t;
  exp_t sb[$];

  int nerr = 0, nchk = 0, cyc = 0;
  int prev_c = 0, prev_s = 0, prev_tol = 0;
  bit done_prev = 1'b0;

  cordic_xy_rotator #(.WIDTH(WIDTH), .ITER(ITER), .X_INIT(39797)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .dir_valid(dir_valid),
    .dir_neg(dir_neg), .dir_ready(dir_ready), .iter_idx(iter_idx), .busy(busy),
    .done(done), .cos_out(cos_out), .sin_out(sin_out)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp_v);
    nchk++;
    if (act != exp_v) begin
      nerr++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp_v);
    end
  endtask

  task automatic chk_tol(input string nm, input int act, input int exp_v, input int tol);
    int d;
    d = act - exp_v;
    if (d < 0) d = -d;
    nchk++;
    if (d > tol) begin
      nerr++;
      $display("FAIL %s actual=%0d required=%0d+/-%0d", nm, act, exp_v, tol);
    end
  endtask

  // Monitor: pops the scoreboard on every done pulse.
  always @(negedge clock) begin
    if (done) begin
      if (done_prev) chk("done_one_cycle", 1, 0);
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_latency", cyc, e.cyc);
        chk_tol("cos_out", int'(cos_out), e.c, e.tol);
        chk_tol("sin_out", int'(sin_out), e.s, e.tol);
      end
    end
    done_prev = done;
  end

  // One conversion; entered and left at a negedge. abort_at >= 0 resets mid-run.
  task automatic run(input bit neg, input int stall_at, input int stall_len,
                     input int pulse_at, input int abort_at);
    exp_t e;
    int   sc;
    sc = neg ? -SIN_E : SIN_E;
    @(negedge clock); start = 1'b1;
    @(posedge clock); #1;
    if (abort_at < 0) begin
      e.c = COS_E; e.s = sc; e.tol = TOL;
      e.cyc = cyc + ITER + 1 + ((stall_at >= 0) ? stall_len : 0);
      sb.push_back(e);
    end
    @(negedge clock); start = 1'b0;
    for (int b = 0; b < ITER; b++) begin
      if (b == stall_at) begin
        for (int s = 0; s < stall_len; s++) begin
          dir_valid = 1'b0;
          @(posedge clock); #1;
          chk("stall_iter_idx", int'(iter_idx), stall_at);
          @(negedge clock);
        end
      end
      if (b == abort_at) begin
        chk("pre_abort_iter_idx", int'(iter_idx), b);
        reset_n = 1'b0;
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_dir_ready", int'(dir_ready), 0);
        chk("rst_iter_idx", int'(iter_idx), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_cos", int'(cos_out), 0);
        chk("rst_sin", int'(sin_out), 0);
        dir_valid = 1'b0;
        @(negedge clock); reset_n = 1'b1;
        prev_c = 0; prev_s = 0; prev_tol = 0;
        repeat (4) @(negedge clock);
        return;
      end
      if (b == 8) begin
        chk_tol("hold_cos", int'(cos_out), prev_c, prev_tol);
        chk_tol("hold_sin", int'(sin_out), prev_s, prev_tol);
      end
      dir_valid = 1'b1;
      dir_neg   = neg;
      start     = (b == pulse_at);
      @(posedge clock); #1;
      @(negedge clock);
    end
    dir_valid = 1'b0;
    start     = 1'b0;
    for (int t = 0; t < 40 && sb.size() != 0; t++) @(negedge clock);
    if (sb.size() != 0) begin
      chk("done_timeout", 0, 1);
      sb.delete();
    end
    prev_c = COS_E; prev_s = sc; prev_tol = TOL;
    repeat (3) @(negedge clock);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; dir_valid = 1'b0; dir_neg = 1'b0;
    repeat (2) @(negedge clock);
    chk("init_busy", int'(busy), 0);
    chk("init_cos", int'(cos_out), 0);
    chk("init_sin", int'(sin_out), 0);
    reset_n = 1'b1;
    @(negedge clock);

    // dir_valid in IDLE must not move the FSM.
    for (int k = 0; k < 3; k++) begin
      dir_valid = 1'b1;
      @(posedge clock); #1;
      chk("idle_busy", int'(busy), 0);
      chk("idle_dir_ready", int'(dir_ready), 0);
      chk("idle_iter_idx", int'(iter_idx), 0);
      @(negedge clock);
    end
    dir_valid = 1'b0;

    run(1'b0, -1, 0, -1, -1);  // all positive
    run(1'b1, -1, 0, -1, -1);  // all negative
    run(1'b1, -1, 0, -1, 7);   // aborted by reset after 7 beats
    run(1'b0, -1, 0, -1, -1);  // fresh run after reset
    run(1'b1, 4, 5, -1, -1);   // negative with stall (prev result held meanwhile)
    run(1'b0, 4, 5, -1, -1);   // positive with stall
    run(1'b0, -1, 0, 8, -1);   // start pulsed mid-run

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/cordic_xy_rotator.md
Name: cordic_xy_rotator

Overview:
- Iterative x/y shift-add datapath directly downstream of the CORDIC angle-accumulation stage.
- Consumes that stage's per-iteration rotation direction (its sign bit), one beat per iteration, and rotates a gain-compensated unit vector.
- After ITER iterations, presents cos/sin of the accumulated angle with a one-cycle done pulse.
- Output feeds the result/output register stage.

Parameters:
- WIDTH, 18, datapath and output width; signed two's complement, 16 fractional bits (1.0 = 65536).
- ITER, 16, number of micro-rotations per conversion (2..31; index counter is 5 bits).
- X_INIT, 39797, initial x value = 1/K (0.607253) in the WIDTH format.

Ports:
- clock  input  1  rising-edge system clock.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  begin a conversion; accepted only in IDLE.
- dir_valid  input  1  direction beat present this cycle.
- dir_neg  input  1  0 = rotate positive (angle below target), 1 = rotate negative.
- dir_ready  output  1  high while in ROTATE; a beat transfers when dir_valid & dir_ready.
- iter_idx  output  5  index of the iteration the next beat applies to; drives the upstream LUT index.
- busy  output  1  high in ROTATE and DONE.
- done  output  1  one-cycle pulse when cos/sin update.
- cos_out  output  WIDTH  signed cosine result, held between conversions.
- sin_out  output  WIDTH  signed sine result, held between conversions.

Behaviour:
- Reset (asynchronous, any state): state = IDLE; x, y, cos_out, sin_out = 0; iter_idx = 0; done = 0; busy = 0; dir_ready = 0. Takes effect immediately; a conversion in flight is discarded with no done pulse.
- Release from reset is synchronous to clock; the first start is honoured on the first rising edge with reset_n high.
- FSM has three states: IDLE, ROTATE, DONE.
- IDLE:
  - start = 1: load x = X_INIT, y = 0, iter_idx = 0, and go to ROTATE.
  - dir_valid in IDLE is ignored.
- ROTATE, on each transfer (dir_valid = 1):
  - dir_neg = 0: x' = x - (y >>> i), y' = y + (x >>> i).
  - dir_neg = 1: x' = x + (y >>> i), y' = y - (x >>> i).
  - i = iter_idx. Shifts are arithmetic. Sums wrap modulo 2^WIDTH with no saturation; magnitudes stay below 1.65, so no overflow occurs with the defaults.
  - Both updates use pre-update x and y from the same cycle.
  - iter_idx increments after each transfer.
  - On the transfer where iter_idx == ITER-1, go to DONE.
- ROTATE without dir_valid: stall; x, y and iter_idx hold, with no limit on stall length.
- start during ROTATE or DONE is ignored and does not restart the conversion.
- DONE (exactly one cycle):
  - cos_out = x, sin_out = y; done = 1 in this cycle only.
  - iter_idx returns to 0 and the FSM returns to IDLE.
  - start seen in DONE is ignored; it must be re-asserted in IDLE.
- Latency: start accepted at edge N, no stalls → beats on edges N+1..N+ITER, done high during the cycle following edge N+ITER+1. Each stall cycle adds one cycle.
- Back-to-back throughput with no stalls: one conversion every ITER+2 cycles.
- cos_out and sin_out change only in DONE and on reset.

Test Plan:
- Reset: assert reset_n = 0 mid-run (after 7 beats) → all outputs 0 immediately, state IDLE, no done pulse. Release and start a fresh all-positive run → correct result (next test) with no residue from the aborted run.
- All positive: start, then 16 beats with dir_neg = 0 (angle ≈ 1.7433 rad) → done exactly 17 cycles after the start edge; cos_out ≈ -11253, sin_out ≈ 64563, each within ±16 LSB.
- All negative: 16 beats with dir_neg = 1 → cos_out ≈ -11253, sin_out ≈ -64563, within ±16.
- Stall: all-positive run with dir_valid low for 5 cycles after beat 4 → identical cos/sin to the all-positive result; done 5 cycles later; iter_idx holds at 4 throughout the stall.
- Ignored inputs:
  - start pulsed at beat 8 → run is unaffected; one done pulse only.
  - dir_valid asserted in IDLE for 3 cycles before start → no state change.
  - cos_out/sin_out hold the previous result until the next done pulse.
